// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with a 2-entry skid buffer, registered in_ready and synchronous flush.
// Optional performance counters (stall_cycles, drop_count) are enabled with `define PIPE_STAGE_SKID_PERF_EN.
module pipe_stage_skid #(
   parameter int unsigned WIDTH = 32
`ifdef PIPE_STAGE_SKID_PERF_EN
   , parameter int unsigned CNT_W = 32
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy
`ifdef PIPE_STAGE_SKID_PERF_EN
   , output logic [CNT_W-1:0] stall_cycles
   , output logic [CNT_W-1:0] drop_count
`endif
);

   // Encoding is {skid_v, main_v}; the (skid only) code is unreachable.
   typedef enum logic [1:0] {
      S_EMPTY = 2'b00,
      S_ONE   = 2'b01,
      S_FULL  = 2'b11
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_in_ready;
   logic [1:0]       r_occ;
   logic [WIDTH-1:0] r_main_d;
   logic [WIDTH-1:0] r_skid_d;

   logic w_clear;
   logic w_in_fire;
   logic w_out_fire;
   logic w_ld_main;
   logic w_main_from_skid;
   logic w_ld_skid;

   assign w_clear    = rst | flush;
   assign w_in_fire  = in_valid & r_in_ready;
   assign w_out_fire = r_state[0] & out_ready;

   // State register, plus the registered handshake/occupancy views of the next state
   always_ff @(posedge clk) begin
      if (w_clear) begin
         r_state    <= S_EMPTY;
         r_in_ready <= 1'b1;
         r_occ      <= 2'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_in_ready <= ~w_state_nxt[1];
         r_occ      <= 2'(w_state_nxt[0]) + 2'(w_state_nxt[1]);
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_EMPTY: if (w_in_fire) w_state_nxt = S_ONE;
         S_ONE: begin
            if (w_in_fire && !w_out_fire)      w_state_nxt = S_FULL;
            else if (!w_in_fire && w_out_fire) w_state_nxt = S_EMPTY;
         end
         S_FULL:  if (w_out_fire) w_state_nxt = S_ONE;
         default: w_state_nxt = S_EMPTY;
      endcase
   end

   // Datapath load controls decoded from state and handshakes
   always_comb begin
      w_ld_main        = 1'b0;
      w_main_from_skid = 1'b0;
      w_ld_skid        = 1'b0;
      unique case (r_state)
         S_EMPTY: w_ld_main = w_in_fire;
         S_ONE: begin
            w_ld_main = w_in_fire & w_out_fire;
            w_ld_skid = w_in_fire & ~w_out_fire;
         end
         S_FULL: begin
            w_ld_main        = w_out_fire;
            w_main_from_skid = 1'b1;
         end
         default: begin
            w_ld_main = 1'b0;
            w_ld_skid = 1'b0;
         end
      endcase
   end

   // Payload registers; flush/rst zero them so stale data never leaks out
   always_ff @(posedge clk) begin
      if (w_clear) begin
         r_main_d <= '0;
         r_skid_d <= '0;
      end else begin
         if (w_ld_main) r_main_d <= w_main_from_skid ? r_skid_d : in_data;
         if (w_ld_skid) r_skid_d <= in_data;
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_state[0];
   assign out_data  = r_main_d;
   assign occupancy = r_occ;

`ifdef PIPE_STAGE_SKID_PERF_EN
   localparam int unsigned SUM_W = CNT_W + 2;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] r_stall;
   logic [CNT_W-1:0] r_drop;
   logic [SUM_W-1:0] w_drop_sum;
   logic [CNT_W-1:0] w_drop_sat;

   assign w_drop_sum = SUM_W'(r_drop) + SUM_W'(r_occ);
   assign w_drop_sat = (w_drop_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : w_drop_sum[CNT_W-1:0];

   // Saturating counters; only rst clears them
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall <= '0;
         r_drop  <= '0;
      end else begin
         if (r_state[0] && !out_ready && (r_stall != CNT_MAX)) r_stall <= r_stall + CNT_W'(1);
         if (flush) r_drop <= w_drop_sat;
      end
   end

   assign stall_cycles = r_stall;
   assign drop_count   = r_drop;
`endif

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
Parametrised pipeline stage register with valid/ready handshake and a 2-entry skid buffer. Generalises the fixed-field decode→execute register: the payload is a WIDTH-bit bus, the stage adds backpressure (stall) and synchronous flush, and it sustains 1 transfer/cycle with a registered in_ready. Instantiated between any two pipeline stages (fetch/decode, decode/execute, ...) with the stage's control and data fields packed into in_data.

Parameters:
WIDTH, 32, payload width in bits (≥1)
CNT_W, 32, width of the performance counters (only with PIPE_STAGE_SKID_PERF_EN)

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  synchronous, active-high reset
flush  input  1  synchronous pipeline flush (bubble insert), same timing as rst but a separate port
in_valid  input  1  upstream has a payload
in_ready  output  1  stage can accept; registered (no comb path from out_ready)
in_data  input  WIDTH  upstream payload
out_valid  output  1  stage holds a valid payload
out_ready  input  1  downstream accepts
out_data  output  WIDTH  payload to downstream; registered
occupancy  output  2  number of held entries, 0..2
stall_cycles  output  CNT_W  (macro only) count of cycles with out_valid=1 and out_ready=0
drop_count  output  CNT_W  (macro only) count of valid entries discarded by flush

Behaviour:
- Definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main register (main_v, main_d) drives out_valid and out_data; skid register (skid_v, skid_d).
- in_ready = !skid_v (from a flop). out_valid = main_v. occupancy = main_v + skid_v.
- States: EMPTY (main_v=0, skid_v=0), ONE (1,0), FULL (1,1). State (0,1) is unreachable.
- EMPTY: in_fire → ONE, main_d<=in_data. Otherwise stays EMPTY.
- ONE: in_fire & out_fire → ONE, main_d<=in_data. in_fire & !out_ready → FULL, skid_d<=in_data. !in_fire & out_fire → EMPTY. Neither → hold.
- FULL: in_ready=0. out_fire → ONE, main_d<=skid_d, skid_v<=0. Otherwise hold.
- Latency: in_data accepted at edge N appears on out_data after edge N (1 cycle). Throughput is 1/cycle when out_ready stays high.
- Stability: while out_valid=1 and out_ready=0, out_data and out_valid do not change.
- flush: next edge clears main_v and skid_v and zeroes main_d and skid_d, so the state becomes EMPTY and in_ready=1. A payload offered (in_fire) in the flush cycle is discarded. flush overrides every handshake transition.
- rst: same effect as flush on the datapath. rst also clears the perf counters. rst has priority over flush.
- Reset values: out_valid=0, out_data=0, in_ready=1, occupancy=0, counters=0.
- After rst or flush deasserts, the first in_fire is accepted normally in the next cycle.

Optional Feature:
PIPE_STAGE_SKID_PERF_EN
- Defined: the stall_cycles and drop_count ports exist.
  - stall_cycles increments each cycle with out_valid & !out_ready.
  - drop_count adds occupancy (0..2) on each flush edge.
  - Both saturate at all-ones and are cleared only by rst. flush does not clear them.
- Undefined: neither port nor counter logic exists. Handshake behaviour is identical.

Test Plan:
1. Reset: hold rst 2 cycles with in_valid=1, in_data=0xDEADBEEF → out_valid=0, out_data=0, in_ready=1, occupancy=0 throughout and after release.
2. Streaming: out_ready=1, push 0x1,0x2,0x3 on consecutive cycles → out_data shows 0x1,0x2,0x3 one cycle later each; occupancy stays ≤1; in_ready stays 1.
3. Backpressure/skid: out_ready=0, push 0xA then 0xB → occupancy=2, in_ready=0, out_data=0xA held stable. Raise out_ready → 0xA, then 0xB delivered in order, in_ready returns 1, no loss or duplication.
4. Flush in FULL: state FULL (0xA,0xB), assert flush with in_valid=1 and in_data=0xC → next cycle out_valid=0, occupancy=0, in_ready=1. 0xA, 0xB and 0xC never appear. With macro: drop_count=2.
5. rst with flush: assert rst and flush together from ONE → EMPTY. With macro: counters=0.
6. Perf (macro): out_ready=0 for 5 cycles with out_valid=1 → stall_cycles=5. Test with CNT_W=3: stall 10 cycles → stall_cycles saturates at 7.
